// File: rtl/enable_pulse_pkg.sv
// Shared types and default constants for the enable_pulse_gen block.
package enable_pulse_pkg;

  // Edge-detect FSM states.
  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } state_t;

  // Default build parameters, reusable by the testbench.
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_REPEAT_DELAY    = 8;
  localparam int unsigned DEF_REPEAT_PERIOD   = 4;

endpackage

// File: rtl/enable_pulse_gen_sync_ff.sv
// Multi-flop synchronizer bringing an asynchronous input into the clk domain.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the synchronizer chain; clears on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/enable_pulse_gen.sv
// Push-button conditioner: synchronizer, saturating debounce counter and
// press-edge FSM producing a one-cycle enable pulse for a downstream counter.
// Optional auto-repeat is compiled in with ENABLE_PULSE_AUTO_REPEAT_EN.
module enable_pulse_gen
  import enable_pulse_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic enable,
  output logic btn_level
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("enable_pulse_gen: parameter out of range");
  end

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          btn_sync;
  logic [DW-1:0] db_cnt;
  logic          db_flip;
  logic          level_rise;
  logic          level_fall;
  state_t        state;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_in),
    .q    (btn_sync)
  );

  // The FSM reacts to the debounced level changing on this same edge, so
  // enable and btn_level rise together rather than enable lagging a cycle.
  always_comb begin
    db_flip    = (btn_sync != btn_level) && (db_cnt == DB_LAST);
    level_rise = db_flip && !btn_level;
    level_fall = db_flip && btn_level;
  end

  // Debounce: count cycles of disagreement, flip the level when saturated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (btn_sync == btn_level) begin
      db_cnt <= '0;
    end else if (db_flip) begin
      db_cnt    <= '0;
      btn_level <= ~btn_level;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

`ifdef ENABLE_PULSE_AUTO_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RPT_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first;

  // Edge FSM with repeat counter: press pulse, then delay, then periodic pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      enable    <= 1'b0;
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else begin
      enable <= 1'b0;
      case (state)
        IDLE: begin
          if (level_rise) begin
            state     <= PRESSED;
            enable    <= 1'b1;
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
          end
        end
        PRESSED: begin
          if (level_fall) begin
            state     <= IDLE;
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
          end else if (rpt_cnt == (rpt_first ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
            enable    <= 1'b1;
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
          end else begin
            rpt_cnt <= rpt_cnt + RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  // Edge FSM: one pulse when the debounced level rises, none on release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      enable <= 1'b0;
    end else begin
      enable <= 1'b0;
      case (state)
        IDLE: begin
          if (level_rise) begin
            state  <= PRESSED;
            enable <= 1'b1;
          end
        end
        PRESSED: begin
          if (level_fall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule
